// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [7:0]    id_ctrl,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_rd_addr,
    input  logic [5:0]    id_funct,
    input  logic          ex_flush,
    input  logic          ex_hold,
    output logic          stall_out,
    output logic          ex_valid,
    output logic [7:0]    ex_ctrl,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [RW-1:0] ex_rs_addr,
    output logic [RW-1:0] ex_rt_addr,
    output logic [RW-1:0] ex_wr_addr,
    output logic [5:0]    ex_funct,
    output logic [CW-1:0] bubble_cnt
);

    logic          ex_valid_q,   ex_valid_d;
    logic [7:0]    ex_ctrl_q,    ex_ctrl_d;
    logic [DW-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DW-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DW-1:0] ex_imm_q,     ex_imm_d;
    logic [DW-1:0] ex_pc4_q,     ex_pc4_d;
    logic [RW-1:0] ex_rs_addr_q, ex_rs_addr_d;
    logic [RW-1:0] ex_rt_addr_q, ex_rt_addr_d;
    logic [RW-1:0] ex_wr_addr_q, ex_wr_addr_d;
    logic [5:0]    ex_funct_q,   ex_funct_d;
    logic [CW-1:0] bubble_cnt_q, bubble_cnt_d;

    logic uses_rt;
    logic hazard;
    logic load_data;

    // A load in EX (MemRead) whose rt is read by the instruction in ID.
    always_comb begin
        uses_rt   = id_ctrl[7] | id_ctrl[6] | id_ctrl[2];
        hazard    = ex_valid_q & ex_ctrl_q[5] & id_valid & (ex_rt_addr_q != '0) &
                    ((ex_rt_addr_q == id_rs_addr) | (uses_rt & (ex_rt_addr_q == id_rt_addr)));
        stall_out = (hazard | ex_hold) & ~ex_flush;
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_imm_d     = ex_imm_q;
        ex_pc4_d     = ex_pc4_q;
        ex_rs_addr_d = ex_rs_addr_q;
        ex_rt_addr_d = ex_rt_addr_q;
        ex_wr_addr_d = ex_wr_addr_q;
        ex_funct_d   = ex_funct_q;
        bubble_cnt_d = bubble_cnt_q;
        load_data    = 1'b0;

        if (ex_flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            load_data  = 1'b1;
        end else if (ex_hold) begin
            load_data  = 1'b0;
        end else if (hazard) begin
            // Bubble: data fields keep their old values, they are dead anyway.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (~&bubble_cnt_q) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end else begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = id_valid ? id_ctrl : 8'h00;
            load_data  = 1'b1;
        end

        if (load_data) begin
            ex_rs_data_d = id_rs_data;
            ex_rt_data_d = id_rt_data;
            ex_imm_d     = id_imm;
            ex_pc4_d     = id_pc4;
            ex_rs_addr_d = id_rs_addr;
            ex_rt_addr_d = id_rt_addr;
            ex_wr_addr_d = id_ctrl[7] ? id_rd_addr : id_rt_addr;
            ex_funct_d   = id_funct;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_pc4_q     <= '0;
            ex_rs_addr_q <= '0;
            ex_rt_addr_q <= '0;
            ex_wr_addr_q <= '0;
            ex_funct_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc4_q     <= ex_pc4_d;
            ex_rs_addr_q <= ex_rs_addr_d;
            ex_rt_addr_q <= ex_rt_addr_d;
            ex_wr_addr_q <= ex_wr_addr_d;
            ex_funct_q   <= ex_funct_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_pc4     = ex_pc4_q;
    assign ex_rs_addr = ex_rs_addr_q;
    assign ex_rt_addr = ex_rt_addr_q;
    assign ex_wr_addr = ex_wr_addr_q;
    assign ex_funct   = ex_funct_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
